// File: rtl/keccak_state_loader.sv
// -----------------------------------------------------------------------------
// keccak_state_loader
//
// Assembles a Keccak state of DEPTH slices (SLICE_W bits each) from a
// valid/ready slice stream. Slice 0 lands in the LSBs. A completed frame is
// presented on state_out with state_valid until state_ack is seen. A malformed
// frame is dropped and reported with a one-cycle frame_err pulse.
//
// Optional feature (macro KECCAK_LOADER_DRAIN_EN):
//   While the state is FULL it can be overwritten through state_in/state_we.
//   After the ack, the state is streamed back out slice by slice on
//   out_valid/out_ready/out_data/out_last before loading resumes.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   in_valid     input slice valid
//   in_ready     loader accepts a slice (registered)
//   in_data      input slice
//   in_last      marks the final slice of a frame
//   state_out    assembled state (SLICE_W*DEPTH bits)
//   state_valid  state_out holds a complete frame
//   state_ack    consumer has taken the state (only honoured when FULL)
//   frame_err    one-cycle pulse: frame ended early or ran past DEPTH slices
//   state_in     [drain] replacement state
//   state_we     [drain] write state_in while FULL
//   out_valid    [drain] output slice valid
//   out_ready    [drain] output slice accepted downstream
//   out_data     [drain] output slice
//   out_last     [drain] marks the final output slice
//
// state  | meaning
// -------+-----------------------------------------------------------
// FILL   | accepting slices, idx = next slice position
// FULL   | frame complete, holding state_out until state_ack
// DRAIN  | [drain] streaming state out, idx = slice being presented
// -----------------------------------------------------------------------------
module keccak_state_loader #(
  parameter int SLICE_W = 25,
  parameter int DEPTH   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W-1:0]       in_data,
  input  logic                     in_last,
  output logic [SLICE_W*DEPTH-1:0] state_out,
  output logic                     state_valid,
  input  logic                     state_ack,
`ifdef KECCAK_LOADER_DRAIN_EN
  input  logic [SLICE_W*DEPTH-1:0] state_in,
  input  logic                     state_we,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W-1:0]       out_data,
  output logic                     out_last,
`endif
  output logic                     frame_err
);

  localparam int S     = SLICE_W * DEPTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1
`ifdef KECCAK_LOADER_DRAIN_EN
    ,
    S_DRAIN = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [S-1:0]     state_reg;
  logic             state_valid_q;
  logic             frame_err_q;
  logic             in_ready_q;
  logic             idx_at_end;
  logic             accept;
`ifdef KECCAK_LOADER_DRAIN_EN
  logic             out_valid_q;
  logic             out_last_q;
`endif

  assign idx_next   = idx + 1'b1;
  assign idx_at_end = (idx == LAST_IDX);
  // in_ready is a flop so it reads 0 during reset and rises on the first
  // edge after release; it tracks "state is FILL" otherwise.
  assign accept     = in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_FILL;
      idx           <= '0;
      state_reg     <= '0;
      state_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      in_ready_q    <= 1'b0;
`ifdef KECCAK_LOADER_DRAIN_EN
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state)
        S_FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (in_last && idx_at_end) begin
              state_reg[SLICE_W*int'(idx) +: SLICE_W] <= in_data;
              state         <= S_FULL;
              state_valid_q <= 1'b1;
              in_ready_q    <= 1'b0;
              idx           <= '0;
            end else if (in_last || idx_at_end) begin
              // Length mismatch: drop this slice, restart at slice 0.
              // Slices already written stay in state_reg.
              frame_err_q <= 1'b1;
              idx         <= '0;
            end else begin
              state_reg[SLICE_W*int'(idx) +: SLICE_W] <= in_data;
              idx <= idx_next;
            end
          end
        end

        S_FULL: begin
`ifdef KECCAK_LOADER_DRAIN_EN
          // A write in the ack cycle still lands, so the drain sees it.
          if (state_we) begin
            state_reg <= state_in;
          end
`endif
          if (state_ack) begin
            state_valid_q <= 1'b0;
            idx           <= '0;
`ifdef KECCAK_LOADER_DRAIN_EN
            state       <= S_DRAIN;
            out_valid_q <= 1'b1;
            out_last_q  <= (DEPTH == 1);
`else
            state       <= S_FILL;
            in_ready_q  <= 1'b1;
`endif
          end
        end

`ifdef KECCAK_LOADER_DRAIN_EN
        S_DRAIN: begin
          if (out_ready) begin
            if (idx_at_end) begin
              state       <= S_FILL;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              idx         <= '0;
            end else begin
              idx        <= idx_next;
              out_last_q <= (idx_next == LAST_IDX);
            end
          end
        end
`endif

        default: begin
          state      <= S_FILL;
          idx        <= '0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign state_out   = state_reg;
  assign state_valid = state_valid_q;
  assign frame_err   = frame_err_q;

`ifdef KECCAK_LOADER_DRAIN_EN
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = state_reg[SLICE_W*int'(idx) +: SLICE_W];
`endif

endmodule

// File: tb/tb_keccak_state_loader.sv
module tb_keccak_state_loader;

  localparam int SW = 25;
  localparam int D  = 64;
  localparam int S  = SW * D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [S-1:0]  state_out;
  logic          state_valid;
  logic          state_ack = 1'b0;
  logic          frame_err;
`ifdef KECCAK_LOADER_DRAIN_EN
  logic [S-1:0]  state_in = '0;
  logic          state_we = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_data;
  logic          out_last;
`endif

  // Reference: the state as an array of slices, updated by the frame rules.
  logic [SW-1:0] mdl [D];

  int vectors     = 0;
  int miscompares = 0;

  keccak_state_loader #(.SLICE_W(SW), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .state_out   (state_out),
    .state_valid (state_valid),
    .state_ack   (state_ack),
`ifdef KECCAK_LOADER_DRAIN_EN
    .state_in    (state_in),
    .state_we    (state_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
`endif
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [S-1:0] e;
    int bad;
    bad = 0;
    for (int i = 0; i < D; i++) e[i*SW +: SW] = mdl[i];
    for (int i = D - 1; i >= 0; i--)
      if (state_out[i*SW +: SW] !== e[i*SW +: SW]) bad = i;
    vectors++;
    assert (state_out === e) else begin
      miscompares++;
      $error("FAIL %s slice %0d observed=%h expected=%h", tag, bad,
             state_out[bad*SW +: SW], e[bad*SW +: SW]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < D; i++) mdl[i] = '0;
  endtask

  // Streams one frame starting at slice position 0. last_at < 0 means in_last
  // is never raised. Expected state contents follow the frame rules: a slice is
  // kept unless it ends the frame at the wrong length.
  task automatic send_frame(input int n, input int last_at, input bit use_k,
                            input int ack_cycles, output bit saw_err);
    logic [SW-1:0] d;
    bit lst;
    saw_err = 1'b0;
    for (int k = 0; k < n; k++) begin
      d   = use_k ? SW'(k) : SW'($urandom);
      lst = (k == last_at);
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = lst;
      state_ack = (k < ack_cycles);
      if (lst == (k == D - 1)) mdl[k] = d;
      tick();
      saw_err |= frame_err;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    state_ack = 1'b0;
  endtask

  task automatic ack_frame(input bit we);
`ifdef KECCAK_LOADER_DRAIN_EN
    int n;
    int cyc;
    bit ready_seen;
`endif
    state_ack = 1'b1;
`ifdef KECCAK_LOADER_DRAIN_EN
    state_we = we;
    state_in = '1;
    if (we) for (int i = 0; i < D; i++) mdl[i] = '1;
`endif
    tick();
    state_ack = 1'b0;
    chk1("ack_valid_clr", state_valid, 1'b0);
`ifdef KECCAK_LOADER_DRAIN_EN
    state_we = 1'b0;
    n = 0;
    cyc = 0;
    ready_seen = 1'b0;
    while (n < D && cyc < 400) begin
      out_ready = (cyc % 2 == 0);
      if (in_ready !== 1'b0) ready_seen = 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        chk1("drain_data", out_data, mdl[n]);
        chk1("drain_last", out_last, (n == D - 1));
        n++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk1("drain_count", n, D);
    chk1("drain_in_ready_low", ready_seen, 1'b0);
    chk1("drain_valid_done", out_valid, 1'b0);
`else
    we = we;
`endif
    chk1("ack_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    bit err;
    logic [S-1:0] held;

    clear_model();
    #3 rst = 1'b0;
    tick();
    tick();
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_state_valid", state_valid, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    chk_state("rst_state_out");
    rst = 1'b1;
    tick();
    chk1("rel_in_ready", in_ready, 1'b1);

`ifdef KECCAK_LOADER_DRAIN_EN
    state_we = 1'b1;
    state_in = '1;
    tick();
    state_we = 1'b0;
    chk_state("we_outside_full");
`endif

    // Frame of data=k, last on slice 63.
    send_frame(D, D - 1, 1'b1, 0, err);
    chk1("k_no_err", err, 1'b0);
    chk1("k_state_valid", state_valid, 1'b1);
    chk1("k_in_ready", in_ready, 1'b0);
    chk1("k_slice0", state_out[SW-1:0], 0);
    chk1("k_slice63", state_out[S-1:S-SW], 63);
    chk_state("k_state_out");
    ack_frame(1'b0);

    // Early in_last on slice 10, with a stray ack during FILL.
    send_frame(11, 10, 1'b0, 3, err);
    chk1("early_err_pulse", frame_err, 1'b1);
    chk1("early_no_valid", state_valid, 1'b0);
    tick();
    chk1("early_err_cleared", frame_err, 1'b0);
    chk1("early_in_ready", in_ready, 1'b1);
    chk_state("early_partial");
    send_frame(D, D - 1, 1'b0, 0, err);
    chk1("after_err_no_err", err, 1'b0);
    chk1("after_err_valid", state_valid, 1'b1);
    chk_state("after_err_state");

    // Held FULL with input pressure.
    held = state_out;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = SW'($urandom);
      in_last  = 1'($urandom);
      tick();
      chk1("hold_in_ready", in_ready, 1'b0);
      chk1("hold_valid", state_valid, 1'b1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk1("hold_stable", (state_out === held), 1'b1);
    chk_state("hold_state");
    ack_frame(1'b0);

    // 64 slices without in_last: overrun on the last slice.
    send_frame(D, -1, 1'b0, 0, err);
    chk1("overrun_err", frame_err, 1'b1);
    chk1("overrun_no_valid", state_valid, 1'b0);
    chk_state("overrun_state");
    tick();
    chk1("overrun_err_clr", frame_err, 1'b0);

    // Reset after slice 30.
    send_frame(31, -1, 1'b0, 0, err);
    chk_state("mid_partial");
    rst = 1'b0;
    #2;
    clear_model();
    chk1("midrst_in_ready", in_ready, 1'b0);
    chk1("midrst_valid", state_valid, 1'b0);
    chk1("midrst_err", frame_err, 1'b0);
    chk_state("midrst_state");
`ifdef KECCAK_LOADER_DRAIN_EN
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_out_last", out_last, 1'b0);
`endif
    tick();
    rst = 1'b1;
    tick();
    chk1("midrst_rel_ready", in_ready, 1'b1);
    send_frame(D, D - 1, 1'b0, 0, err);
    chk1("fresh_no_err", err, 1'b0);
    chk1("fresh_valid", state_valid, 1'b1);
    chk_state("fresh_state");
    ack_frame(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
